pc_flow_ctrl: RTL and testbench

// Program-flow controller driving the pc counter's jump interface (skok_pc, skok_pc_stos, adres_*, reti_int_en, ID_rst).

---
 rtl/pc_flow_ctrl_if.sv | 45 ++++
 rtl/pc_flow_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_flow_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pc_flow_ctrl_if.sv
// Decoder/pc-facing bundle of the program-flow controller: decoder ops and pc state in, jump controls out.
// Master is the decoder/pc side, slave is pc_flow_ctrl.
interface pc_flow_ctrl_if #(
  parameter int W     = 8,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           instr_valid;
  logic           op_jmp;
  logic           op_call;
  logic           op_ret;
  logic           op_reti;
  logic           op_ei;
  logic           op_di;
  logic [W-1:0]   jmp_addr;
  logic [W-1:0]   pc_in;
  logic           irq;

  logic           skok_pc;
  logic           skok_pc_stos;
  logic [W-1:0]   adres_skok_pc;
  logic [W-1:0]   adres_skok_pc_stos;
  logic           reti_int_en;
  logic           pc_rst;
  logic           flush;
  logic           irq_ack;
  logic           int_en;
  logic           stack_err;
  logic [SPW-1:0] sp;

  modport master (
    output instr_valid, op_jmp, op_call, op_ret, op_reti, op_ei, op_di,
           jmp_addr, pc_in, irq,
    input  skok_pc, skok_pc_stos, adres_skok_pc, adres_skok_pc_stos,
           reti_int_en, pc_rst, flush, irq_ack, int_en, stack_err, sp
  );

  modport slave (
    input  instr_valid, op_jmp, op_call, op_ret, op_reti, op_ei, op_di,
           jmp_addr, pc_in, irq,
    output skok_pc, skok_pc_stos, adres_skok_pc, adres_skok_pc_stos,
           reti_int_en, pc_rst, flush, irq_ack, int_en, stack_err, sp
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Program-flow controller: branch decisions, return-address stack, interrupt entry and one-cycle flush bubble.
// Jump controls are combinational (pc loads on the same edge); flush/pc_rst/int_en/sp/stack_err are registered.
module pc_flow_ctrl #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 8,
  parameter logic [W-1:0] IRQ_VEC = 8'h04
) (
  input  logic         clk,
  input  logic         rst,
  pc_flow_ctrl_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, ERR} state_t;

  state_t         state_q;
  logic [SPW-1:0] sp_q;
  logic           int_en_q;
  logic           irq_pend_q;
  logic           stack_err_q;
  logic           flush_q;
  logic           pc_rst_q;
  logic [W-1:0]   stack_q [DEPTH];

  logic run, dec, is_jmp, is_call, is_ret, is_reti, branch;
  logic irq_take, push, pop, full, empty, ovf, unf, err, jump;
  logic [AW-1:0] push_idx, top_idx;

  assign run     = (state_q == RUN);
  assign dec     = run && bus.instr_valid;
  assign is_jmp  = dec && bus.op_jmp;
  assign is_call = dec && bus.op_call;
  assign is_ret  = dec && bus.op_ret;
  assign is_reti = dec && bus.op_reti;
  assign branch  = is_jmp || is_call || is_ret || is_reti;

  // Decoder branches outrank interrupt entry; a deferred irq stays pending.
  assign irq_take = run && irq_pend_q && int_en_q && !branch;

  assign full  = (sp_q == FULL_SP);
  assign empty = (sp_q == '0);
  assign push  = is_call || irq_take;
  assign pop   = is_ret || is_reti;
  assign ovf   = push && full;
  assign unf   = pop && empty;
  assign err   = ovf || unf;
  assign jump  = is_jmp || (push && !full) || (pop && !empty);

  assign push_idx = AW'(sp_q);
  assign top_idx  = AW'(sp_q - 1'b1);

  assign bus.skok_pc            = jump;
  assign bus.skok_pc_stos       = pop && !empty;
  assign bus.reti_int_en        = is_reti && !empty;
  assign bus.irq_ack            = irq_take && !full;
  assign bus.adres_skok_pc      = irq_take             ? IRQ_VEC      :
                                  (is_jmp || is_call)  ? bus.jmp_addr : '0;
  assign bus.adres_skok_pc_stos = empty ? '0 : stack_q[top_idx];
  assign bus.pc_rst             = pc_rst_q;
  assign bus.flush              = flush_q;
  assign bus.int_en             = int_en_q;
  assign bus.stack_err          = stack_err_q;
  assign bus.sp                 = sp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      sp_q        <= '0;
      int_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      stack_err_q <= 1'b0;
      flush_q     <= 1'b0;
      pc_rst_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          irq_pend_q <= irq_pend_q | bus.irq;
          if (err) begin
            stack_err_q <= 1'b1;
            pc_rst_q    <= 1'b1;
            state_q     <= ERR;
          end else begin
            if (push) begin
              stack_q[push_idx] <= bus.pc_in;
              sp_q              <= sp_q + 1'b1;
            end
            if (pop) sp_q <= sp_q - 1'b1;
            // Entry preempts the instruction at pc_in, so any ei/di with it is dropped.
            if (irq_take) begin
              int_en_q   <= 1'b0;
              irq_pend_q <= 1'b0;
            end else if (is_reti || (dec && bus.op_ei)) begin
              int_en_q <= 1'b1;
            end else if (dec && bus.op_di) begin
              int_en_q <= 1'b0;
            end
            if (jump) begin
              flush_q <= 1'b1;
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          irq_pend_q <= irq_pend_q | bus.irq;
          flush_q    <= 1'b0;
          state_q    <= RUN;
        end
        default: begin
          pc_rst_q   <= 1'b0;
          sp_q       <= '0;
          int_en_q   <= 1'b0;
          irq_pend_q <= 1'b0;
          state_q    <= RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: call/ret, irq entry/reti, branch-vs-irq priority, stack errors, flush and reset.
module tb_pc_flow_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_flow_ctrl_if #(.W(8), .DEPTH(8)) bus ();
  pc_flow_ctrl #(.W(8), .DEPTH(8), .IRQ_VEC(8'h04)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic clr_ops();
    bus.instr_valid = 0; bus.op_jmp = 0; bus.op_call = 0; bus.op_ret = 0;
    bus.op_reti = 0; bus.op_ei = 0; bus.op_di = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr_ops(); bus.jmp_addr = 0; bus.pc_in = 0; bus.irq = 0;
    rst = 1; tick(); tick(); rst = 0; #1;
    checks++; if (bus.sp !== 4'd0) begin failures++; $display("FAIL rst_sp got=%0d exp=0", bus.sp); end
    checks++; if (bus.int_en !== 1'b0) begin failures++; $display("FAIL rst_int_en got=%b exp=0", bus.int_en); end
    checks++; if ({bus.flush, bus.pc_rst, bus.stack_err} !== 3'b000) begin failures++; $display("FAIL rst_regs got=%b exp=000", {bus.flush, bus.pc_rst, bus.stack_err}); end
    checks++; if ({bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en, bus.irq_ack} !== 4'b0000 || bus.adres_skok_pc_stos !== 8'h00 || bus.adres_skok_pc !== 8'h00) begin
      failures++; $display("FAIL rst_comb got=%b stos=%0h adr=%0h exp=0000/0/0", {bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en, bus.irq_ack}, bus.adres_skok_pc_stos, bus.adres_skok_pc); end
  endtask

  task automatic test_call_ret();
    bus.pc_in = 8'h10; bus.jmp_addr = 8'h40; bus.instr_valid = 1; bus.op_call = 1; #1;
    checks++; if (bus.skok_pc !== 1'b1 || bus.adres_skok_pc !== 8'h40 || bus.skok_pc_stos !== 1'b0) begin
      failures++; $display("FAIL call_jump got skok=%b adr=%0h stos=%b exp 1/40/0", bus.skok_pc, bus.adres_skok_pc, bus.skok_pc_stos); end
    tick(); clr_ops(); #1;
    checks++; if (bus.sp !== 4'd1 || bus.flush !== 1'b1) begin failures++; $display("FAIL call_sp_flush got sp=%0d flush=%b exp 1/1", bus.sp, bus.flush); end
    checks++; if (bus.adres_skok_pc_stos !== 8'h10) begin failures++; $display("FAIL call_stos got=%0h exp=10", bus.adres_skok_pc_stos); end
    tick();
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got=%b exp=0", bus.flush); end
    bus.instr_valid = 1; bus.op_ret = 1; #1;
    checks++; if ({bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en} !== 3'b110 || bus.adres_skok_pc_stos !== 8'h10) begin
      failures++; $display("FAIL ret_comb got=%b stos=%0h exp=110/10", {bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en}, bus.adres_skok_pc_stos); end
    tick(); clr_ops(); #1;
    checks++; if (bus.sp !== 4'd0 || bus.flush !== 1'b1) begin failures++; $display("FAIL ret_sp got sp=%0d flush=%b exp 0/1", bus.sp, bus.flush); end
    tick();
  endtask

  task automatic test_irq();
    bus.instr_valid = 1; bus.op_ei = 1; tick(); clr_ops(); #1;
    checks++; if (bus.int_en !== 1'b1) begin failures++; $display("FAIL ei got=%b exp=1", bus.int_en); end
    bus.pc_in = 8'h22; bus.irq = 1; tick(); #1;
    checks++; if (bus.irq_ack !== 1'b1 || bus.skok_pc !== 1'b1 || bus.adres_skok_pc !== 8'h04) begin
      failures++; $display("FAIL irq_entry got ack=%b skok=%b adr=%0h exp 1/1/04", bus.irq_ack, bus.skok_pc, bus.adres_skok_pc); end
    bus.irq = 0; tick();
    checks++; if (bus.int_en !== 1'b0 || bus.sp !== 4'd1 || bus.flush !== 1'b1) begin
      failures++; $display("FAIL irq_state got int_en=%b sp=%0d flush=%b exp 0/1/1", bus.int_en, bus.sp, bus.flush); end
    tick();
    bus.instr_valid = 1; bus.op_reti = 1; #1;
    checks++; if ({bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en} !== 3'b111 || bus.adres_skok_pc_stos !== 8'h22) begin
      failures++; $display("FAIL reti_comb got=%b stos=%0h exp=111/22", {bus.skok_pc, bus.skok_pc_stos, bus.reti_int_en}, bus.adres_skok_pc_stos); end
    tick(); clr_ops(); #1;
    checks++; if (bus.int_en !== 1'b1 || bus.sp !== 4'd0) begin failures++; $display("FAIL reti_state got int_en=%b sp=%0d exp 1/0", bus.int_en, bus.sp); end
    tick();
  endtask

  task automatic test_jmp_priority();
    bus.irq = 1; tick();
    bus.pc_in = 8'h2F; bus.jmp_addr = 8'h30; bus.instr_valid = 1; bus.op_jmp = 1; #1;
    checks++; if (bus.irq_ack !== 1'b0 || bus.skok_pc !== 1'b1 || bus.adres_skok_pc !== 8'h30) begin
      failures++; $display("FAIL jmp_wins got ack=%b skok=%b adr=%0h exp 0/1/30", bus.irq_ack, bus.skok_pc, bus.adres_skok_pc); end
    tick(); clr_ops(); bus.irq = 0; bus.pc_in = 8'h30; #1;
    checks++; if (bus.irq_ack !== 1'b0 || bus.skok_pc !== 1'b0 || bus.sp !== 4'd0) begin
      failures++; $display("FAIL flush_no_irq got ack=%b skok=%b sp=%0d exp 0/0/0", bus.irq_ack, bus.skok_pc, bus.sp); end
    tick();
    checks++; if (bus.irq_ack !== 1'b1 || bus.adres_skok_pc !== 8'h04) begin
      failures++; $display("FAIL deferred_irq got ack=%b adr=%0h exp 1/04", bus.irq_ack, bus.adres_skok_pc); end
    tick(); tick();
    bus.instr_valid = 1; bus.op_reti = 1; #1;
    checks++; if (bus.adres_skok_pc_stos !== 8'h30 || bus.reti_int_en !== 1'b1) begin
      failures++; $display("FAIL deferred_push got stos=%0h reti_en=%b exp 30/1", bus.adres_skok_pc_stos, bus.reti_int_en); end
    tick(); clr_ops(); tick();
    bus.instr_valid = 1; bus.op_di = 1; tick(); clr_ops(); #1;
    checks++; if (bus.int_en !== 1'b0) begin failures++; $display("FAIL di got=%b exp=0", bus.int_en); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      bus.pc_in = 8'h50 + 8'(i); bus.jmp_addr = 8'h60; bus.instr_valid = 1; bus.op_call = 1;
      tick(); clr_ops(); tick();
    end
    checks++; if (bus.sp !== 4'd8 || bus.adres_skok_pc_stos !== 8'h57) begin
      failures++; $display("FAIL full_stack got sp=%0d stos=%0h exp 8/57", bus.sp, bus.adres_skok_pc_stos); end
    bus.pc_in = 8'h58; bus.instr_valid = 1; bus.op_call = 1; #1;
    checks++; if (bus.skok_pc !== 1'b0) begin failures++; $display("FAIL ovf_no_jump got=%b exp=0", bus.skok_pc); end
    tick(); clr_ops(); #1;
    checks++; if (bus.sp !== 4'd8 || bus.stack_err !== 1'b1 || bus.pc_rst !== 1'b1 || bus.flush !== 1'b0) begin
      failures++; $display("FAIL ovf_err got sp=%0d err=%b pc_rst=%b flush=%b exp 8/1/1/0", bus.sp, bus.stack_err, bus.pc_rst, bus.flush); end
    tick();
    checks++; if (bus.sp !== 4'd0 || bus.pc_rst !== 1'b0 || bus.stack_err !== 1'b1) begin
      failures++; $display("FAIL ovf_recover got sp=%0d pc_rst=%b err=%b exp 0/0/1", bus.sp, bus.pc_rst, bus.stack_err); end
  endtask

  task automatic test_underflow();
    bus.instr_valid = 1; bus.op_ret = 1; #1;
    checks++; if (bus.skok_pc !== 1'b0 || bus.skok_pc_stos !== 1'b0) begin
      failures++; $display("FAIL unf_no_jump got skok=%b stos=%b exp 0/0", bus.skok_pc, bus.skok_pc_stos); end
    tick(); clr_ops(); #1;
    checks++; if (bus.pc_rst !== 1'b1 || bus.flush !== 1'b0 || bus.sp !== 4'd0) begin
      failures++; $display("FAIL unf_err got pc_rst=%b flush=%b sp=%0d exp 1/0/0", bus.pc_rst, bus.flush, bus.sp); end
    tick();
    checks++; if (bus.pc_rst !== 1'b0) begin failures++; $display("FAIL unf_pulse got=%b exp=0", bus.pc_rst); end
  endtask

  task automatic test_flush_ignore();
    bus.pc_in = 8'h11; bus.jmp_addr = 8'h40; bus.instr_valid = 1; bus.op_call = 1; tick(); #1;
    checks++; if (bus.skok_pc !== 1'b0 || bus.sp !== 4'd1) begin
      failures++; $display("FAIL flush_call_comb got skok=%b sp=%0d exp 0/1", bus.skok_pc, bus.sp); end
    tick(); clr_ops(); #1;
    checks++; if (bus.sp !== 4'd1 || bus.flush !== 1'b0) begin
      failures++; $display("FAIL flush_call_ignored got sp=%0d flush=%b exp 1/0", bus.sp, bus.flush); end
  endtask

  task automatic test_rst_in_flush();
    rst = 1; tick(); rst = 0;
    bus.instr_valid = 1; bus.op_ei = 1; tick(); clr_ops();
    bus.pc_in = 8'h10; bus.jmp_addr = 8'h40; bus.instr_valid = 1; bus.op_call = 1; tick(); clr_ops(); #1;
    checks++; if (bus.sp !== 4'd1 || bus.flush !== 1'b1 || bus.int_en !== 1'b1) begin
      failures++; $display("FAIL pre_rst got sp=%0d flush=%b int_en=%b exp 1/1/1", bus.sp, bus.flush, bus.int_en); end
    rst = 1; tick(); rst = 0; #1;
    checks++; if (bus.sp !== 4'd0 || {bus.flush, bus.int_en, bus.pc_rst, bus.stack_err} !== 4'b0000) begin
      failures++; $display("FAIL rst_flush got sp=%0d regs=%b exp 0/0000", bus.sp, {bus.flush, bus.int_en, bus.pc_rst, bus.stack_err}); end
    checks++; if ({bus.skok_pc, bus.skok_pc_stos, bus.irq_ack} !== 3'b000 || bus.adres_skok_pc_stos !== 8'h00) begin
      failures++; $display("FAIL rst_flush_comb got=%b stos=%0h exp 000/0", {bus.skok_pc, bus.skok_pc_stos, bus.irq_ack}, bus.adres_skok_pc_stos); end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_irq();
    test_jmp_priority();
    test_overflow();
    test_underflow();
    test_flush_ignore();
    test_rst_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
